// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and legality check.
package lsu_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUS  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Stores only have signed-agnostic encodings, so the unsigned variants are illegal for them.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Combinational load formatter: selects the addressed byte/half/word lane and extends it.
module lsu_load_fmt
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [2:0]            funct3_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o   = '0;
    case (funct3_i)
      F3_B:    data_o = {{(DATA_WIDTH - 8){byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {{(DATA_WIDTH - 8){1'b0}}, byte_sel};
      F3_H:    data_o = {{(DATA_WIDTH - 16){half_sel[15]}}, half_sel};
      F3_HU:   data_o = {{(DATA_WIDTH - 16){1'b0}}, half_sel};
      F3_W:    data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: one bus transaction per memory instruction, stalling the core until done.
// Optional misaligned-access suppression is enabled by defining LSU_MISALIGN_EXC_EN.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  misalign_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [BE_WIDTH-1:0]   mem_be_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  lsu_state_e state_q, state_d;

  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_WIDTH-1:0]   mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  misalign_q, misalign_d;

  logic                  legal;
  logic                  is_half;
  logic                  is_word;
  logic                  suppress;
  logic                  mis_flag;
  logic [1:0]            addr_lo_eff;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [BE_WIDTH-1:0]   st_be;
  logic [DATA_WIDTH-1:0] load_data;

  assign legal   = f3_legal(we_i, funct3_i);
  assign is_half = (funct3_i[1:0] == 2'b01);
  assign is_word = (funct3_i[1:0] == 2'b10);

`ifdef LSU_MISALIGN_EXC_EN
  logic misaligned_req;
  assign misaligned_req = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));
  assign mis_flag       = legal & misaligned_req;
  assign suppress       = ~legal | misaligned_req;
  assign addr_lo_eff    = addr_i[1:0];
`else
  // Misaligned halves/words silently snap to their natural alignment.
  assign mis_flag    = 1'b0;
  assign suppress    = ~legal;
  assign addr_lo_eff = is_word ? 2'b00 : (is_half ? {addr_i[1], 1'b0} : addr_i[1:0]);
`endif

  always_comb begin
    st_wdata = '0;
    st_be    = {BE_WIDTH{1'b1}};
    if (we_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          st_wdata = {4{wdata_i[7:0]}};
          st_be    = BE_WIDTH'(1) << addr_lo_eff;
        end
        2'b01: begin
          st_wdata = {2{wdata_i[15:0]}};
          st_be    = BE_WIDTH'(3) << {addr_lo_eff[1], 1'b0};
        end
        default: st_wdata = wdata_i;
      endcase
    end
  end

  lsu_load_fmt #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_fmt (
    .rdata_i  (mem_rdata_i),
    .addr_lo_i(addr_lo_q),
    .funct3_i (funct3_q),
    .data_o   (load_data)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    rdata_d     = rdata_q;
    misalign_d  = misalign_q;
    stall_o     = 1'b0;
    done_o      = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        if (req_i) begin
          stall_o    = 1'b1;
          we_d       = we_i;
          funct3_d   = funct3_i;
          addr_lo_d  = addr_lo_eff;
          rdata_d    = '0;
          misalign_d = mis_flag;
          if (suppress) begin
            state_d = LSU_DONE;
          end else begin
            state_d     = LSU_BUS;
            mem_req_d   = 1'b1;
            mem_we_d    = we_i;
            mem_addr_d  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_d = st_wdata;
            mem_be_d    = st_be;
          end
        end
      end
      LSU_BUS: begin
        stall_o = 1'b1;
        if (mem_ready_i) begin
          rdata_d   = we_q ? '0 : load_data;
          mem_req_d = 1'b0;
          state_d   = LSU_DONE;
        end
      end
      LSU_DONE: begin
        // The core advances on this edge, so the next instruction is first seen in IDLE.
        done_o  = 1'b1;
        state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= LSU_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      rdata_q     <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;
  assign rdata_o     = rdata_q;
  assign misalign_o  = misalign_q;

endmodule
